// File: rtl/data_mem_hs.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_hs
//  Purpose  : MIPS data memory with sized accesses (byte/half/word), sign or
//             zero extension of loads and WAIT_CYCLES wait states behind a
//             valid/ready request and a one-cycle response pulse.
//  Options  : `define DMEM_MISALIGN_TRAP_EN to flag misaligned half/word
//             accesses (memory untouched, resp_err=1, resp_rdata=0).
//  Ports    : clk, rst           - clock, synchronous active-high reset
//             req_valid/ready    - request handshake (ready only in IDLE)
//             req_write          - 1 store, 0 load
//             req_size           - 00 byte, 01 half, 1x word
//             req_unsigned       - loads: 1 zero-extend, 0 sign-extend
//             req_addr/req_wdata - byte address, right-aligned store data
//             resp_valid         - one-cycle completion pulse
//             resp_rdata/err     - extended load data, misalignment flag
//  Revision : 1.0 - initial release
// ============================================================================
module data_mem_hs #(
   parameter int ADDR_W      = 6,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int         c_DEPTH    = 2 ** ADDR_W;
   localparam logic [3:0] c_CNT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [3:0]          r_cnt;
   logic                r_write;
   logic [1:0]          r_size;
   logic                r_unsigned;
   logic [ADDR_W+1:0]   r_addr;
   logic [31:0]         r_wdata;
   logic [31:0]         r_rdata;
   logic                r_err;
   logic [31:0]         r_mem [c_DEPTH];

   logic                w_start;
   logic                w_fire;
   logic                w_a_write;
   logic [1:0]          w_a_size;
   logic                w_a_unsigned;
   logic [ADDR_W+1:0]   w_a_addr;
   logic [31:0]         w_a_wdata;
   logic [ADDR_W-1:0]   w_idx;
   logic [1:0]          w_lane;
   logic [31:0]         w_old;
   logic [3:0]          w_be;
   logic [31:0]         w_sdata;
   logic [31:0]         w_new;
   logic [7:0]          w_byte;
   logic [15:0]         w_half;
   logic [31:0]         w_load;
   logic                w_mis;
   logic                w_unused_addr;

   assign w_unused_addr = ^req_addr[31:ADDR_W+2];

   assign w_start = (r_state == S_IDLE) && req_valid;

   // With no wait states the access happens on the acceptance edge itself,
   // so operands come straight from the request ports instead of the latches.
   assign w_fire       = (WAIT_CYCLES == 0) ? w_start
                                            : ((r_state == S_WAIT) && (r_cnt == 4'd0));
   assign w_a_write    = (WAIT_CYCLES == 0) ? req_write    : r_write;
   assign w_a_size     = (WAIT_CYCLES == 0) ? req_size     : r_size;
   assign w_a_unsigned = (WAIT_CYCLES == 0) ? req_unsigned : r_unsigned;
   assign w_a_addr     = (WAIT_CYCLES == 0) ? req_addr[ADDR_W+1:0] : r_addr;
   assign w_a_wdata    = (WAIT_CYCLES == 0) ? req_wdata    : r_wdata;

   assign w_idx  = w_a_addr[ADDR_W+1:2];
   assign w_lane = w_a_addr[1:0];
   assign w_old  = r_mem[w_idx];

`ifdef DMEM_MISALIGN_TRAP_EN
   assign w_mis = ((w_a_size == 2'b01) && w_lane[0]) ||
                  (w_a_size[1] && (w_lane != 2'b00));
`else
   assign w_mis = 1'b0;
`endif

   // FSM: state register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // FSM: next state and handshake outputs
   always_comb begin
      w_next     = r_state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      case (r_state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) w_next = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
         end
         S_WAIT: if (r_cnt == 4'd0) w_next = S_RESP;
         S_RESP: begin
            resp_valid = 1'b1;
            w_next     = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Store lane enables and replicated data, then merge with the old word
   always_comb begin
      w_be    = 4'b1111;
      w_sdata = w_a_wdata;
      case (w_a_size)
         2'b00: begin
            w_be    = 4'b0001 << w_lane;
            w_sdata = {4{w_a_wdata[7:0]}};
         end
         2'b01: begin
            w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
            w_sdata = {2{w_a_wdata[15:0]}};
         end
         default: ;
      endcase
      for (int i = 0; i < 4; i++)
         w_new[8*i +: 8] = w_be[i] ? w_sdata[8*i +: 8] : w_old[8*i +: 8];
   end

   // Load extraction and extension
   always_comb begin
      case (w_lane)
         2'd0:    w_byte = w_old[7:0];
         2'd1:    w_byte = w_old[15:8];
         2'd2:    w_byte = w_old[23:16];
         default: w_byte = w_old[31:24];
      endcase
      w_half = w_lane[1] ? w_old[31:16] : w_old[15:0];
      case (w_a_size)
         2'b00:   w_load = w_a_unsigned ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
         2'b01:   w_load = w_a_unsigned ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
         default: w_load = w_old;
      endcase
   end

   // Request latch, wait counter, memory array and response data
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt      <= 4'd0;
         r_write    <= 1'b0;
         r_size     <= 2'b00;
         r_unsigned <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= 32'd0;
         r_rdata    <= 32'd0;
         r_err      <= 1'b0;
         for (int i = 0; i < c_DEPTH; i++) r_mem[i] <= 32'd0;
      end else begin
         if (w_start) begin
            r_write    <= req_write;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_addr     <= req_addr[ADDR_W+1:0];
            r_wdata    <= req_wdata;
            r_cnt      <= c_CNT_LOAD;
         end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (w_fire) begin
            if (w_a_write && !w_mis) r_mem[w_idx] <= w_new;
            r_rdata <= (w_a_write || w_mis) ? 32'd0 : w_load;
            r_err   <= w_mis;
         end
      end
   end

   assign resp_rdata = r_rdata;
   assign resp_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_hs.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_mem_hs
//  Purpose  : Self-checking bench for data_mem_hs. Three instances with
//             WAIT_CYCLES of 0, 1 and 3 share the request bus; 'sel' routes
//             req_valid to one of them and muxes its outputs back. Expected
//             responses are queued when a request is driven and compared when
//             resp_valid appears.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_hs;

`ifdef DMEM_MISALIGN_TRAP_EN
   localparam bit c_TRAP = 1'b1;
`else
   localparam bit c_TRAP = 1'b0;
`endif

   function automatic int wc_of(input int s);
      return (s == 0) ? 0 : (s == 1) ? 1 : 3;
   endfunction

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          sel = 0;
   logic        req_valid = 1'b0;
   logic        req_write = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;

   logic        vin   [3];
   logic        rdy_o [3];
   logic        rv_o  [3];
   logic [31:0] rd_o  [3];
   logic        err_o [3];

   logic        req_ready, resp_valid, resp_err;
   logic [31:0] resp_rdata;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      assign vin[g] = req_valid && (sel == g);
      data_mem_hs #(.ADDR_W(6), .WAIT_CYCLES(wc_of(g))) u_dut (
         .clk          (clk),
         .rst          (rst),
         .req_valid    (vin[g]),
         .req_ready    (rdy_o[g]),
         .req_write    (req_write),
         .req_size     (req_size),
         .req_unsigned (req_unsigned),
         .req_addr     (req_addr),
         .req_wdata    (req_wdata),
         .resp_valid   (rv_o[g]),
         .resp_rdata   (rd_o[g]),
         .resp_err     (err_o[g])
      );
   end

   always_comb begin
      req_ready  = rdy_o[sel];
      resp_valid = rv_o[sel];
      resp_rdata = rd_o[sel];
      resp_err   = err_o[sel];
   end

   int total = 0;
   int bad   = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   typedef struct packed {
      logic [31:0] d;
      logic        e;
   } exp_t;
   exp_t sb [$];
   exp_t mon_x;

   // Scoreboard consumer
   always @(negedge clk) begin
      if (!rst && resp_valid === 1'b1) begin
         if (sb.size() == 0) begin
            check_val("unexpected_resp", 32'd1, 32'd0);
         end else begin
            mon_x = sb.pop_front();
            check_val("rdata", resp_rdata, mon_x.d);
            check_val("err", {31'b0, resp_err}, {31'b0, mon_x.e});
         end
      end
   end

   task automatic do_req(input int s, input logic wr, input logic [1:0] sz, input logic un,
                         input logic [31:0] ad, input logic [31:0] wd,
                         input logic [31:0] ed, input logic ee, input bit intrude);
      int lat;
      int low;
      bit seen;
      @(negedge clk);
      sel = s; req_valid = 1'b1; req_write = wr; req_size = sz;
      req_unsigned = un; req_addr = ad; req_wdata = wd;
      #1;
      check_val("ready_idle", {31'b0, req_ready}, 32'd1);
      sb.push_back('{d: ed, e: ee});
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0; low = 0; seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
         @(negedge clk);
         lat++;
         if (!req_ready) low++;
         if (resp_valid) seen = 1'b1;
         else if (intrude && lat == 1) begin
            req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10;
            req_addr = 32'h34; req_wdata = 32'h5555_5555;
         end else if (intrude && lat == 2) req_valid = 1'b0;
      end
      req_valid = 1'b0;
      if (!seen) check_val("timeout", 32'd0, 32'd1);
      else begin
         check_val("latency", 32'(lat), 32'(wc_of(s) + 1));
         check_val("ready_low", 32'(low), 32'(wc_of(s) + 1));
      end
   endtask

   task automatic quiet_check(input string tag);
      int n;
      n = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (resp_valid) n++;
      end
      check_val(tag, 32'(n), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check_val("rst_valid", {31'b0, rv_o[i]}, 32'd0);
         check_val("rst_rdata", rd_o[i], 32'd0);
         check_val("rst_err", {31'b0, err_o[i]}, 32'd0);
         check_val("rst_ready", {31'b0, rdy_o[i]}, 32'd1);
      end

      // WAIT_CYCLES=1 instance: sized stores/loads and extension
      do_req(1, 0, 2'd2, 0, 32'h3C,  32'd0,        32'h0000_0000, 0, 0);
      do_req(1, 1, 2'd2, 0, 32'h08,  32'h11223344, 32'h0000_0000, 0, 0);
      do_req(1, 1, 2'd0, 0, 32'h09,  32'h0000_00AA, 32'h0000_0000, 0, 0);
      do_req(1, 0, 2'd2, 0, 32'h08,  32'd0,        32'h1122_AA44, 0, 0);
      do_req(1, 0, 2'd0, 0, 32'h09,  32'd0,        32'hFFFF_FFAA, 0, 0);
      do_req(1, 0, 2'd0, 1, 32'h09,  32'd0,        32'h0000_00AA, 0, 0);
      do_req(1, 0, 2'd1, 0, 32'h0A,  32'd0,        32'h0000_1122, 0, 0);
      do_req(1, 0, 2'd0, 1, 32'h0B,  32'd0,        32'h0000_0011, 0, 0);
      do_req(1, 1, 2'd1, 0, 32'h0E,  32'h0000_8001, 32'h0000_0000, 0, 0);
      do_req(1, 0, 2'd1, 0, 32'h0E,  32'd0,        32'hFFFF_8001, 0, 0);
      do_req(1, 0, 2'd1, 1, 32'h0E,  32'd0,        32'h0000_8001, 0, 0);
      do_req(1, 0, 2'd3, 1, 32'h0C,  32'd0,        32'h8001_0000, 0, 0);
      // Address wrap
      do_req(1, 1, 2'd2, 0, 32'h100, 32'hDEADBEEF, 32'h0000_0000, 0, 0);
      do_req(1, 0, 2'd2, 0, 32'h000, 32'd0,        32'hDEAD_BEEF, 0, 0);
      // Misaligned accesses
      do_req(1, 1, 2'd2, 0, 32'h20,  32'h12345678, 32'h0000_0000, 0, 0);
      do_req(1, 1, 2'd1, 0, 32'h21,  32'h0000_BEEF, 32'h0000_0000, c_TRAP, 0);
      do_req(1, 0, 2'd2, 0, 32'h20,  32'd0, c_TRAP ? 32'h1234_5678 : 32'h1234_BEEF, 0, 0);
      do_req(1, 0, 2'd2, 0, 32'h0A,  32'd0, c_TRAP ? 32'h0 : 32'h1122_AA44, c_TRAP, 0);
      do_req(1, 0, 2'd1, 1, 32'h0B,  32'd0, c_TRAP ? 32'h0 : 32'h0000_1122, c_TRAP, 0);

      // WAIT_CYCLES=0 instance
      do_req(0, 1, 2'd2, 0, 32'h04,  32'h0BADF00D, 32'h0000_0000, 0, 0);
      do_req(0, 0, 2'd2, 0, 32'h04,  32'd0,        32'h0BAD_F00D, 0, 0);
      do_req(0, 0, 2'd1, 1, 32'h06,  32'd0,        32'h0000_0BAD, 0, 0);
      do_req(0, 0, 2'd0, 0, 32'h05,  32'd0,        32'hFFFF_FFF0, 0, 0);

      // WAIT_CYCLES=3 instance: request arriving during WAIT is dropped
      do_req(2, 1, 2'd2, 0, 32'h30,  32'h600D600D, 32'h0000_0000, 0, 1);
      do_req(2, 0, 2'd2, 0, 32'h34,  32'd0,        32'h0000_0000, 0, 0);
      do_req(2, 0, 2'd2, 0, 32'h30,  32'd0,        32'h600D_600D, 0, 0);

      // Reset during WAIT abandons a store
      @(negedge clk);
      sel = 2; req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2;
      req_addr = 32'h10; req_wdata = 32'hCAFEF00D;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk) rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      quiet_check("abort_no_resp");
      do_req(2, 0, 2'd2, 0, 32'h10,  32'd0,        32'h0000_0000, 0, 0);

      // Reset in the same cycle as req_valid: not accepted
      @(negedge clk);
      sel = 2; rst = 1'b1; req_valid = 1'b1; req_write = 1'b1;
      req_addr = 32'h14; req_wdata = 32'h0000_0077;
      @(negedge clk);
      rst = 1'b0; req_valid = 1'b0;
      check_val("rst_req_ready", {31'b0, req_ready}, 32'd1);
      quiet_check("rst_req_no_resp");
      do_req(2, 0, 2'd2, 0, 32'h14,  32'd0,        32'h0000_0000, 0, 0);

      repeat (4) @(negedge clk);
      check_val("sb_drain", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
